id_ex_register: RTL and testbench

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/id_ex_register.sv | 103 ++++++++++
 tb/tb_id_ex_register.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: synchronous reset, flush-to-bubble, stall-hold.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_COUNT_EN.
module id_ex_register #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [3:0]        id_funct,
  input  logic [1:0]        id_aluop,
  input  logic              id_branch,
  input  logic              id_memread,
  input  logic              id_memtoreg,
  input  logic              id_memwrite,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
`ifdef ID_EX_BUBBLE_COUNT_EN
  output logic [31:0]       bubble_count,
`endif
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [3:0]        ex_funct,
  output logic [1:0]        ex_aluop,
  output logic              ex_branch,
  output logic              ex_memread,
  output logic              ex_memtoreg,
  output logic              ex_memwrite,
  output logic              ex_alusrc,
  output logic              ex_regwrite
);

  // A bubble is loaded on reset, flush, or an unstalled edge with no real instruction.
  logic load_bubble;
  assign load_bubble = reset || flush || (!stall && !in_valid);

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
      ex_aluop    <= '0;
      ex_branch   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
    end else if (!stall) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct    <= id_funct;
      ex_aluop    <= id_aluop;
      ex_branch   <= id_branch;
      ex_memread  <= id_memread;
      ex_memtoreg <= id_memtoreg;
      ex_memwrite <= id_memwrite;
      ex_alusrc   <= id_alusrc;
      ex_regwrite <= id_regwrite;
    end
  end

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0] bubble_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count_q <= '0;
    end else if (load_bubble && (bubble_count_q != 32'hFFFF_FFFF)) begin
      bubble_count_q <= bubble_count_q + 32'd1;
    end
  end

  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Directed testbench for id_ex_register; bubble counter checks run only
// when ID_EX_BUBBLE_COUNT_EN is defined.
module tb_id_ex_register;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic reset, stall, flush, in_valid;
  logic [DATA_W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_funct;
  logic [1:0] id_aluop;
  logic id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
  logic ex_valid;
  logic [DATA_W-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_funct;
  logic [1:0] ex_aluop;
  logic ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0] bubble_count;
  logic [31:0] bc_before;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_register #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct), .id_aluop(id_aluop),
    .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
`ifdef ID_EX_BUBBLE_COUNT_EN
    .bubble_count(bubble_count),
`endif
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_aluop(ex_aluop), .ex_branch(ex_branch), .ex_memread(ex_memread),
    .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite)
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; stall = 0; flush = 0; in_valid = 0;
    id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct = '0; id_aluop = '0;
    id_branch = 0; id_memread = 0; id_memtoreg = 0; id_memwrite = 0; id_alusrc = 0; id_regwrite = 0;
  endtask

  task automatic test_reset();
    reset = 1; stall = 1; flush = 1; in_valid = 1;
    id_pc = '1; id_rs1_data = '1; id_rs2_data = '1; id_imm = '1;
    id_rs1 = '1; id_rs2 = '1; id_rd = '1; id_funct = '1; id_aluop = '1;
    id_branch = 1; id_memread = 1; id_memtoreg = 1; id_memwrite = 1; id_alusrc = 1; id_regwrite = 1;
    tick(); tick();
    n_vec++;
    if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    n_vec++;
    if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm} !== '0) begin
      n_err++; $display("FAIL reset_data got pc=%h rs1d=%h rs2d=%h imm=%h want 0", ex_pc, ex_rs1_data, ex_rs2_data, ex_imm);
    end
    n_vec++;
    if ({ex_rs1, ex_rs2, ex_rd, ex_funct, ex_aluop} !== 21'd0) begin
      n_err++; $display("FAIL reset_fields got %h want 0", {ex_rs1, ex_rs2, ex_rd, ex_funct, ex_aluop});
    end
    n_vec++;
    if ({ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl got %b want 000000",
        {ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite});
    end
`ifdef ID_EX_BUBBLE_COUNT_EN
    n_vec++;
    if (bubble_count !== 32'd0) begin n_err++; $display("FAIL reset_bcount got %h want 0", bubble_count); end
`endif
    clear_inputs();
  endtask

  task automatic test_load_rtype();
    in_valid = 1; id_aluop = 2'b10; id_funct = 4'b1000; id_rd = 5'd5;
    id_rs1_data = 64'h10; id_regwrite = 1;
    tick();
    n_vec++;
    if ({ex_valid, ex_aluop, ex_funct, ex_rd, ex_regwrite} !== {1'b1, 2'b10, 4'b1000, 5'd5, 1'b1}) begin
      n_err++; $display("FAIL load_rtype got v=%b op=%b f=%b rd=%0d rw=%b want v=1 op=10 f=1000 rd=5 rw=1",
        ex_valid, ex_aluop, ex_funct, ex_rd, ex_regwrite);
    end
    n_vec++;
    if (ex_rs1_data !== 64'h10) begin n_err++; $display("FAIL load_rs1data got %h want 10", ex_rs1_data); end
    clear_inputs();
  endtask

  task automatic test_load_all_fields();
    in_valid = 1; id_pc = 64'hDEAD_BEEF_0000_1234; id_rs1_data = 64'hA5A5_0000_FFFF_0001;
    id_rs2_data = 64'h8000_0000_0000_0000; id_imm = 64'hFFFF_FFFF_FFFF_FFF0;
    id_rs1 = 5'd31; id_rs2 = 5'd17; id_rd = 5'd1; id_funct = 4'b0111; id_aluop = 2'b01;
    id_branch = 1; id_memread = 0; id_memtoreg = 1; id_memwrite = 0; id_alusrc = 1; id_regwrite = 0;
    tick();
    n_vec++;
    if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm} !==
        {64'hDEAD_BEEF_0000_1234, 64'hA5A5_0000_FFFF_0001, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0}) begin
      n_err++; $display("FAIL load_data got pc=%h rs1d=%h rs2d=%h imm=%h", ex_pc, ex_rs1_data, ex_rs2_data, ex_imm);
    end
    n_vec++;
    if ({ex_rs1, ex_rs2, ex_rd, ex_funct, ex_aluop} !== {5'd31, 5'd17, 5'd1, 4'b0111, 2'b01}) begin
      n_err++; $display("FAIL load_fields got rs1=%0d rs2=%0d rd=%0d f=%b op=%b want 31 17 1 0111 01",
        ex_rs1, ex_rs2, ex_rd, ex_funct, ex_aluop);
    end
    n_vec++;
    if ({ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite} !== 6'b101010) begin
      n_err++; $display("FAIL load_ctrl got %b want 101010",
        {ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite});
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    in_valid = 1; id_pc = 64'h100; id_regwrite = 1;
    tick();
    n_vec++;
    if (ex_pc !== 64'h100) begin n_err++; $display("FAIL stall_preload got %h want 100", ex_pc); end
    stall = 1; id_pc = 64'h104; id_regwrite = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (ex_pc !== 64'h100 || ex_regwrite !== 1'b1 || ex_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold%0d got pc=%h rw=%b v=%b want pc=100 rw=1 v=1", i, ex_pc, ex_regwrite, ex_valid);
      end
    end
    stall = 0;
    tick();
    n_vec++;
    if (ex_pc !== 64'h104 || ex_regwrite !== 1'b0) begin
      n_err++; $display("FAIL stall_release got pc=%h rw=%b want pc=104 rw=0", ex_pc, ex_regwrite);
    end
    clear_inputs();
  endtask

  task automatic test_flush_stall();
    in_valid = 1; id_aluop = 2'b10; id_regwrite = 1; id_memwrite = 1; id_pc = 64'h40;
    tick();
`ifdef ID_EX_BUBBLE_COUNT_EN
    bc_before = bubble_count;
`endif
    stall = 1; flush = 1;
    tick();
    n_vec++;
    if ({ex_valid, ex_regwrite, ex_memwrite, ex_aluop} !== 5'b0 || ex_pc !== '0) begin
      n_err++; $display("FAIL flush_stall got v=%b rw=%b mw=%b op=%b pc=%h want all 0",
        ex_valid, ex_regwrite, ex_memwrite, ex_aluop, ex_pc);
    end
`ifdef ID_EX_BUBBLE_COUNT_EN
    n_vec++;
    if (bubble_count !== bc_before + 32'd1) begin
      n_err++; $display("FAIL flush_bcount got %h want %h", bubble_count, bc_before + 32'd1);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_bubble_in_valid();
    in_valid = 1; id_rd = 5'd9; id_regwrite = 1;
    tick();
`ifdef ID_EX_BUBBLE_COUNT_EN
    bc_before = bubble_count;
`endif
    in_valid = 0; id_memwrite = 1; id_memread = 1; id_branch = 1; id_rd = 5'd3; id_pc = 64'h55;
    tick();
    n_vec++;
    if ({ex_valid, ex_memwrite, ex_memread, ex_branch, ex_regwrite} !== 5'b0 || ex_rd !== 5'd0 || ex_pc !== '0) begin
      n_err++; $display("FAIL bubble_invalid got v=%b mw=%b mr=%b br=%b rw=%b rd=%0d pc=%h want all 0",
        ex_valid, ex_memwrite, ex_memread, ex_branch, ex_regwrite, ex_rd, ex_pc);
    end
`ifdef ID_EX_BUBBLE_COUNT_EN
    n_vec++;
    if (bubble_count !== bc_before + 32'd1) begin
      n_err++; $display("FAIL invalid_bcount got %h want %h", bubble_count, bc_before + 32'd1);
    end
    bc_before = bubble_count;
    stall = 1;
    tick(); tick();
    n_vec++;
    if (bubble_count !== bc_before) begin
      n_err++; $display("FAIL stall_bcount got %h want %h", bubble_count, bc_before);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1; id_pc = 64'h200; id_regwrite = 1;
    tick();
    stall = 1;
    tick();
    reset = 1;
    tick();
    n_vec++;
    if (ex_valid !== 1'b0 || ex_pc !== '0 || ex_regwrite !== 1'b0) begin
      n_err++; $display("FAIL reset_midstall got v=%b pc=%h rw=%b want 0", ex_valid, ex_pc, ex_regwrite);
    end
    reset = 0; stall = 0; id_pc = 64'h300;
    tick();
    n_vec++;
    if (ex_valid !== 1'b1 || ex_pc !== 64'h300 || ex_regwrite !== 1'b1) begin
      n_err++; $display("FAIL post_reset_load got v=%b pc=%h rw=%b want v=1 pc=300 rw=1", ex_valid, ex_pc, ex_regwrite);
    end
    clear_inputs();
  endtask

`ifdef ID_EX_BUBBLE_COUNT_EN
  task automatic test_saturation();
    force dut.bubble_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_count_q;
    flush = 1;
    tick();
    n_vec++;
    if (bubble_count !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL sat_first got %h want ffffffff", bubble_count);
    end
    tick(); tick();
    n_vec++;
    if (bubble_count !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL sat_hold got %h want ffffffff", bubble_count);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_load_rtype();
    test_load_all_fields();
    test_stall();
    test_flush_stall();
    test_bubble_in_valid();
    test_reset_mid_stall();
`ifdef ID_EX_BUBBLE_COUNT_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
